pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised next-generation program counter for the MIPS datapath. Selects the
//  next fetch address from increment, absolute load, PC-relative branch, return-address
//  pop or exception vector. Adds stall, a return-address stack (RAS) for call/return,
//  and EPC capture. Sits between the control FSM and instruction-memory address port.
// PARAMETERS
//  WIDTH      32         PC/address width in bits (>=16)
//  STEP       4          increment in bytes per instruction
//  RAS_DEPTH  4          return-address stack entries (power of 2, >=2)
//  RESET_VEC  32'h0      PC value on reset (truncated to WIDTH)
//  EXC_VEC    32'h80     PC value loaded on exception
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-high reset
//  pc_stall   in   1          hold PC and RAS (exception still honoured)
//  pc_ld      in   1          load PC_in (absolute jump / jr)
//  pc_br      in   1          PC <= PC_out + STEP + (sign-extended br_off << 2)
//  pc_ret     in   1          PC <= popped RAS top
//  pc_inc     in   1          PC <= PC_out + STEP
//  pc_call    in   1          qualifier: push PC_out+STEP when pc_ld or pc_br is taken
//  exc_req    in   1          exception: PC <= EXC_VEC, capture epc
//  PC_in      in   WIDTH      absolute target
//  br_off     in   16         signed word offset
//  PC_out     out  WIDTH      current PC (registered)
//  pc_plus    out  WIDTH      PC_out + STEP (combinational, mod 2^WIDTH)
//  epc        out  WIDTH      PC_out at last accepted exc_req (registered)
//  ras_cnt    out  $clog2(RAS_DEPTH+1)  valid RAS entries
//  ras_ovf    out  1          sticky: push while full; cleared only by reset
//  ras_unf    out  1          one-cycle pulse: pc_ret with RAS empty
// BEHAVIOUR
//  Reset (async, immediate): PC_out=RESET_VEC, epc=0, ras_cnt=0, ras_ovf=0, ras_unf=0,
//   RAS pointer=0. Deassertion: first update on next rising clk.
//  Per-edge priority (highest first); exactly one action per cycle:
//   1 exc_req : PC_out<=EXC_VEC; epc<=PC_out; RAS untouched; ignores pc_stall.
//   2 pc_stall: PC_out, RAS, ras_cnt hold; ras_unf<=0.
//   3 pc_ld   : PC_out<=PC_in; if pc_call push pc_plus.
//   4 pc_br   : PC_out<=pc_plus+{sext(br_off),2'b00}; if pc_call push pc_plus.
//   5 pc_ret  : RAS non-empty -> PC_out<=top, pop, ras_cnt-1.
//               RAS empty -> PC_out<=PC_in (fallback), ras_unf<=1, ras_cnt stays 0.
//   6 pc_inc  : PC_out<=pc_plus.
//   none      : hold.
//  Latency: one clk from control to PC_out; pc_plus is zero-latency from PC_out.
//  Arithmetic: all sums mod 2^WIDTH; wrap from max to low is silent.
//  RAS: circular, top = last push. Push while full (ras_cnt==RAS_DEPTH) overwrites
//   oldest entry, ras_cnt stays RAS_DEPTH, ras_ovf<=1 (sticky).
//  pc_call without pc_ld/pc_br taken (lower priority won or stalled): ignored.
//  ras_unf is 0 on every cycle except the one following an empty pop.
//  Reset mid-operation: all state cleared immediately; no partial push/pop survives.
// CONFIGURATION
//  PC_ALIGN_TRAP_EN defined: extra output misalign (1 bit, reset 0). Any pc_ld/pc_ret
//   target with low two bits !=0 is not loaded; instead PC_out<=EXC_VEC, epc<=target,
//   misalign<=1 for one cycle; RAS pop still performed, push suppressed.
//  Undefined: no misalign port; targets loaded verbatim, low bits unchecked.
// TESTING
//  1 reset high mid-run with PC=0x40 -> PC_out=RESET_VEC immediately; ras_cnt=0.
//  2 pc_inc x3 from 0 -> PC_out 4,8,0xC; pc_stall=1 with pc_inc -> PC_out holds 0xC.
//  3 PC=0x100, pc_br br_off=16'hFFFE -> PC_out=0xFC; pc_br+pc_call at 0x200 br_off=3
//    -> PC_out=0x210, ras_cnt=1, then pc_ret -> PC_out=0x204, ras_cnt=0.
//  4 RAS_DEPTH=4: five pc_ld+pc_call pushes (A..E) -> ras_ovf=1, ras_cnt=4; four
//    pc_ret return E,D,C,B; fifth pc_ret with PC_in=0x500 -> PC_out=0x500, ras_unf=1.
//  5 PC=0x30, exc_req with pc_stall=1 and pc_ld=1 -> PC_out=EXC_VEC(0x80), epc=0x30.
//  6 PC_ALIGN_TRAP_EN: pc_ld PC_in=0x102 -> PC_out=0x80, epc=0x102, misalign pulse;
//    without macro -> PC_out=0x102.

Source files
------------

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Next-fetch-address generator for the MIPS datapath. Picks the
//                next PC from increment, absolute load, PC-relative branch,
//                return-address-stack pop or the exception vector. It also
//                supports stall, a circular return-address stack (RAS) for
//                call/return, and EPC capture.
//
//  Parameters  : WIDTH      PC/address width in bits (>=16)
//                STEP       byte increment per instruction
//                RAS_DEPTH  RAS entries (power of 2, >=2)
//                RESET_VEC  PC value while reset is asserted
//                EXC_VEC    PC value loaded on an exception
//
//  Ports       : clk, reset (async, active-high)
//                pc_stall, pc_ld, pc_br, pc_ret, pc_inc, pc_call, exc_req
//                  - control inputs. Their priority is exc_req > pc_stall >
//                    pc_ld > pc_br > pc_ret > pc_inc.
//                PC_in   - absolute target, also the fallback for an empty pop
//                br_off  - signed word offset for branches
//                PC_out  - registered current PC
//                pc_plus - PC_out + STEP (combinational)
//                epc     - PC_out captured at the last accepted exception
//                ras_cnt - number of valid RAS entries
//                ras_ovf - sticky flag: a push happened while the RAS was full
//                ras_unf - one-cycle pulse after a pop from an empty RAS
//
//  Build option: PC_ALIGN_TRAP_EN - adds the output misalign. A pc_ld/pc_ret
//                target whose two low bits are not 00 then traps to EXC_VEC,
//                records the bad target in epc and pulses misalign.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int          WIDTH     = 32,
    parameter int          STEP      = 4,
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_VEC = 32'h0,
    parameter logic [31:0] EXC_VEC   = 32'h80
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pc_stall,
    input  logic                           pc_ld,
    input  logic                           pc_br,
    input  logic                           pc_ret,
    input  logic                           pc_inc,
    input  logic                           pc_call,
    input  logic                           exc_req,
    input  logic [WIDTH-1:0]               PC_in,
    input  logic [15:0]                    br_off,
    output logic [WIDTH-1:0]               PC_out,
    output logic [WIDTH-1:0]               pc_plus,
    output logic [WIDTH-1:0]               epc,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt,
    output logic                           ras_ovf,
    output logic                           ras_unf
`ifdef PC_ALIGN_TRAP_EN
    ,
    output logic                           misalign
`endif
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    localparam logic [WIDTH-1:0] c_reset_vec = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] c_exc_vec   = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] c_step      = WIDTH'(STEP);
    localparam logic [CW-1:0]    c_depth     = CW'(RAS_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    // r_ptr points at the slot the next push writes. The top of the stack
    // is at r_ptr-1. Wrap-around is modulo RAS_DEPTH, so a push into a full
    // stack overwrites the oldest entry.
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic             r_mis;

    // ------------------------------------------------------------------
    // Combinational next-state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_br_off_ext;
    logic [WIDTH-1:0] w_br_tgt;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_empty;

    logic [WIDTH-1:0] w_tgt;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_epc_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_unf_nxt;
    logic             w_mis_nxt;

    assign w_pc_plus    = r_pc + c_step;
    // Shift the word offset to a byte offset, then sign-extend it to WIDTH.
    assign w_br_off_ext = WIDTH'($signed({br_off, 2'b00}));
    assign w_br_tgt     = w_pc_plus + w_br_off_ext;
    assign w_ras_top    = r_ras[r_ptr - 1'b1];
    assign w_ras_empty  = (r_cnt == '0);

    always_comb begin
        w_tgt     = PC_in;
        w_pc_nxt  = r_pc;
        w_epc_nxt = r_epc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_unf_nxt = 1'b0;
        w_mis_nxt = 1'b0;

        if (exc_req) begin
            w_pc_nxt  = c_exc_vec;
            w_epc_nxt = r_pc;
        end else if (pc_stall) begin
            // Hold everything. ras_unf returns to 0 by default.
        end else if (pc_ld) begin
            w_tgt = PC_in;
`ifdef PC_ALIGN_TRAP_EN
            if (w_tgt[1:0] != 2'b00) begin
                w_pc_nxt  = c_exc_vec;
                w_epc_nxt = w_tgt;
                w_mis_nxt = 1'b1;
            end else begin
                w_pc_nxt = w_tgt;
                w_push   = pc_call;
            end
`else
            w_pc_nxt = w_tgt;
            w_push   = pc_call;
`endif
        end else if (pc_br) begin
            w_pc_nxt = w_br_tgt;
            w_push   = pc_call;
        end else if (pc_ret) begin
            if (!w_ras_empty) begin
                w_tgt = w_ras_top;
                w_pop = 1'b1;
            end else begin
                // An empty stack falls back to the absolute target.
                w_tgt     = PC_in;
                w_unf_nxt = 1'b1;
            end
`ifdef PC_ALIGN_TRAP_EN
            // The pop still happens when the popped target traps.
            if (w_tgt[1:0] != 2'b00) begin
                w_pc_nxt  = c_exc_vec;
                w_epc_nxt = w_tgt;
                w_mis_nxt = 1'b1;
            end else begin
                w_pc_nxt = w_tgt;
            end
`else
            w_pc_nxt = w_tgt;
`endif
        end else if (pc_inc) begin
            w_pc_nxt = w_pc_plus;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= c_reset_vec;
            r_epc <= '0;
            r_ptr <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_mis <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            r_pc  <= w_pc_nxt;
            r_epc <= w_epc_nxt;
            r_unf <= w_unf_nxt;
            r_mis <= w_mis_nxt;
            if (w_push) begin
                r_ras[r_ptr] <= w_pc_plus;
                r_ptr        <= r_ptr + 1'b1;
                if (r_cnt == c_depth) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_pop) begin
                r_ptr <= r_ptr - 1'b1;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign PC_out  = r_pc;
    assign pc_plus = w_pc_plus;
    assign epc     = r_epc;
    assign ras_cnt = r_cnt;
    assign ras_ovf = r_ovf;
    assign ras_unf = r_unf;
`ifdef PC_ALIGN_TRAP_EN
    assign misalign = r_mis;
`else
    // Without the trap option the misalign register has no output. It stays
    // at 0 because w_mis_nxt is never set.
    logic w_mis_unused;
    assign w_mis_unused = r_mis;
`endif

endmodule
`default_nettype wire
